// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
// Owns the PC and keeps exactly one word fetch in flight to instruction memory.
// It buffers the returned word with its PC for decode and honours redirects
// from execute at any point in the fetch cycle.
// Optional feature macro: IFU_PERF_EN adds the delivered-instruction and
// decode-stall counters (perf_fetch_cnt, perf_stall_cnt).
//
// Handshake rule for every channel (imem request, decode output): a transfer
// happens on a rising edge where valid and ready are both high. Once valid is
// raised, the payload is held until that transfer happens. The only exception
// is a redirect, which may retarget the request or flush the buffered output.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
`ifdef IFU_PERF_EN
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt,
`endif
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetchState_e;

  localparam logic [63:0] PcRst = RESET_PC;

  fetchState_e state, stateNext;
  logic [63:0] pc, pcNext;
  logic        drop, dropNext;
  logic [63:0] outPcQ, outPcNext;
  logic [31:0] outInstQ, outInstNext;

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= PcRst;
      drop     <= 1'b0;
      outPcQ   <= '0;
      outInstQ <= '0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      drop     <= dropNext;
      outPcQ   <= outPcNext;
      outInstQ <= outInstNext;
    end
  end

  // Next-state logic. A redirect always overrides the sequential PC update.
  // drop marks an in-flight fetch whose response belongs to a stale address.
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    dropNext    = drop;
    outPcNext   = outPcQ;
    outInstNext = outInstQ;
    case (state)
      BOOT: begin
        stateNext = REQ;
        if (redirect_valid) pcNext = redirect_pc;
      end
      REQ: begin
        if (imem_req_ready) begin
          stateNext = WAIT;
          if (redirect_valid) begin
            pcNext   = redirect_pc;
            dropNext = 1'b1;
          end
        end else if (redirect_valid) begin
          pcNext = redirect_pc;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            // Response for the old path dies here; the new path refetches.
            pcNext    = redirect_pc;
            dropNext  = 1'b0;
            stateNext = REQ;
          end else if (drop) begin
            dropNext  = 1'b0;
            stateNext = REQ;
          end else begin
            outInstNext = imem_resp_data;
            outPcNext   = pc;
            stateNext   = HOLD;
          end
        end else if (redirect_valid) begin
          pcNext   = redirect_pc;
          dropNext = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pcNext    = redirect_pc;
          stateNext = REQ;
        end else if (out_ready) begin
          pcNext    = pc + 64'd4;
          stateNext = REQ;
        end
      end
      default: stateNext = BOOT;
    endcase
  end

  // All outputs come straight from registers/state.
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign out_valid      = (state == HOLD);
  assign out_pc         = outPcQ;
  assign out_inst       = outInstQ;
  assign dbgState       = state;

`ifdef IFU_PERF_EN
  // Delivered-instruction and decode-backpressure counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (out_valid) begin
      if (out_ready) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      else           perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch. It runs directed scenarios for reset, stall,
// redirect and wrap, then a randomized run. A behavioural memory and an
// expected-PC model check every cycle.
`timescale 1ns/1ps
module tb_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  dbgState;
`ifdef IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
  logic [63:0] expFetch;
  logic [63:0] expStall;
`endif

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
`ifdef IFU_PERF_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
`endif
    .dbgState        (dbgState)
  );

  // Clock generation and global time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Scoreboard and model state.
  int          nChecks = 0;
  int          nPass   = 0;
  logic [63:0] exp_q[$];        // expected request addresses, in order
  logic [63:0] expPc;           // address the next fetch/delivery must carry
  logic        memBusy;
  int          memCnt;
  logic [63:0] memAddr;
  bit          memManual;
  int          delayLo = 1;
  int          delayHi = 1;
  logic        prevStall;
  logic [63:0] prevAddr;
  logic        prevGone;
  int          nHandshake;
  int          nDeliver;
  int          idle;

  // Memory contents: a scrambled function of the address, 0x413 at RESET_PC.
  function automatic logic [31:0] memFn(input logic [63:0] a);
    logic [31:0] x;
    x = a[31:0] ^ 32'h8000_0000 ^ a[63:32];
    return x * 32'h9E37_79B1 + 32'h0000_0413;
  endfunction

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic resetModel();
    expPc      = RESET_PC;
    memBusy    = 1'b0;
    memCnt     = 0;
    memAddr    = '0;
    prevStall  = 1'b0;
    prevAddr   = '0;
    prevGone   = 1'b0;
    nHandshake = 0;
    nDeliver   = 0;
    idle       = 0;
    exp_q.delete();
`ifdef IFU_PERF_EN
    expFetch = '0;
    expStall = '0;
`endif
  endtask

  // Per-cycle reference model: expected PC stream, memory, handshake rules.
  task automatic modelCycle();
    if (imem_req_valid) begin
      checkEq("req_addr", imem_req_addr, expPc);
      if (!memManual) checkEq("one_outstanding", 64'(memBusy), 64'd0);
    end
    if (prevStall) begin
      checkEq("req_hold_valid", 64'(imem_req_valid), 64'd1);
      checkEq("req_hold_addr", imem_req_addr, prevAddr);
    end
    if (prevGone) checkEq("out_flush", 64'(out_valid), 64'd0);
    if (out_valid) begin
      checkEq("out_pc", out_pc, expPc);
      if (!memManual) checkEq("out_inst", 64'(out_inst), 64'(memFn(expPc)));
    end
`ifdef IFU_PERF_EN
    checkEq("perf_fetch", perf_fetch_cnt, expFetch);
    checkEq("perf_stall", perf_stall_cnt, expStall);
    if (out_valid) begin
      if (out_ready) expFetch = expFetch + 64'd1;
      else           expStall = expStall + 64'd1;
    end
`endif
    if (imem_req_valid && imem_req_ready) begin
      nHandshake++;
      if (exp_q.size() > 0) checkEq("req_seq", imem_req_addr, exp_q.pop_front());
    end
    if (!memManual) begin
      if (imem_resp_valid) memBusy = 1'b0;
      else if (memBusy)    memCnt--;
      if (imem_req_valid && imem_req_ready) begin
        memBusy = 1'b1;
        memAddr = imem_req_addr;
        memCnt  = int'($urandom_range(delayHi, delayLo)) - 1;
      end
    end
    if (out_valid && out_ready) begin
      nDeliver++;
      idle = 0;
    end else begin
      idle++;
    end
    prevStall = imem_req_valid && !imem_req_ready && !redirect_valid;
    prevAddr  = imem_req_addr;
    prevGone  = out_valid && (out_ready || redirect_valid);
    if (redirect_valid)              expPc = redirect_pc;
    else if (out_valid && out_ready) expPc = expPc + 64'd4;
  endtask

  // Driver: memory response for this cycle, model check, advance one clock.
  task automatic step();
    if (!memManual) begin
      if (memBusy && memCnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memFn(memAddr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
    end
    #1;
    modelCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    out_ready       = 1'b0;
    memManual       = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #2;
    checkEq("rst_req_valid", 64'(imem_req_valid), 64'd0);
    checkEq("rst_req_addr", imem_req_addr, RESET_PC);
    checkEq("rst_out_valid", 64'(out_valid), 64'd0);
    checkEq("rst_out_pc", out_pc, 64'd0);
    checkEq("rst_out_inst", 64'(out_inst), 64'd0);
`ifdef IFU_PERF_EN
    checkEq("rst_perf_fetch", perf_fetch_cnt, 64'd0);
    checkEq("rst_perf_stall", perf_stall_cnt, 64'd0);
`endif
    rst = 1'b0;
  endtask

  task automatic stepUntilOut(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      step();
    end
    checkEq(tag, 64'(out_valid), 64'd1);
  endtask

  initial begin
    // Reset release, always-ready memory, 1-cycle response.
    delayLo = 1; delayHi = 1;
    doReset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    exp_q.push_back(64'h8000_0000);
    exp_q.push_back(64'h8000_0004);
    checkEq("t1_boot_idle", 64'(imem_req_valid), 64'd0);
    step();
    checkEq("t1_first_req", 64'(imem_req_valid), 64'd1);
    checkEq("t1_first_addr", imem_req_addr, 64'h8000_0000);
    step();
    checkEq("t1_wait_no_out", 64'(out_valid), 64'd0);
    step();
    checkEq("t1_out_valid", 64'(out_valid), 64'd1);
    checkEq("t1_out_pc", out_pc, 64'h8000_0000);
    checkEq("t1_out_inst", 64'(out_inst), 64'h0000_0413);
    step();
    checkEq("t1_next_req", 64'(imem_req_valid), 64'd1);
    checkEq("t1_next_addr", imem_req_addr, 64'h8000_0004);
    step();
    checkEq("t1_seq_done", 64'(exp_q.size()), 64'd0);

    // Request held off for 3 cycles: stable address, single acceptance.
    doReset();
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      checkEq("t2_hold_valid", 64'(imem_req_valid), 64'd1);
      checkEq("t2_hold_addr", imem_req_addr, 64'h8000_0000);
      step();
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    repeat (6) step();
    checkEq("t2_one_accept", 64'(nHandshake), 64'd1);

    // Redirect while waiting for the response: stale data never reaches decode.
    delayLo = 3; delayHi = 3;
    doReset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (imem_req_valid) break;
      checkEq("t3_no_stale", 64'(out_valid), 64'd0);
      step();
    end
    checkEq("t3_req_valid", 64'(imem_req_valid), 64'd1);
    checkEq("t3_req_addr", imem_req_addr, 64'h8000_0100);

    // Redirect in HOLD with decode not ready: buffer flushed.
    delayLo = 1; delayHi = 1;
    doReset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    stepUntilOut("t4_reach_hold");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    checkEq("t4_flushed", 64'(out_valid), 64'd0);
    checkEq("t4_req_valid", 64'(imem_req_valid), 64'd1);
    checkEq("t4_req_addr", imem_req_addr, 64'h8000_0200);

    // Decode stalls 5 cycles: output stable, then accepted.
    doReset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    stepUntilOut("t5_reach_hold");
    for (int i = 0; i < 5; i++) begin
      step();
      checkEq("t5_stable_valid", 64'(out_valid), 64'd1);
      checkEq("t5_stable_pc", out_pc, RESET_PC);
      checkEq("t5_stable_inst", 64'(out_inst), 64'h0000_0413);
    end
`ifdef IFU_PERF_EN
    checkEq("t5_perf_stall", perf_stall_cnt, 64'd5);
`endif
    out_ready = 1'b1;
    step();
    checkEq("t5_accepted", 64'(out_valid), 64'd0);
`ifdef IFU_PERF_EN
    checkEq("t5_perf_fetch", perf_fetch_cnt, 64'd1);
    checkEq("t5_perf_stall_after", perf_stall_cnt, 64'd5);
`endif

    // Reset in WAIT; the late response lands in BOOT and must be ignored.
    doReset();
    memManual      = 1'b1;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    checkEq("t6_async_req_valid", 64'(imem_req_valid), 64'd0);
    checkEq("t6_async_out_valid", 64'(out_valid), 64'd0);
    checkEq("t6_async_req_addr", imem_req_addr, RESET_PC);
    resetModel();
    @(posedge clk);
    #2;
    rst             = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    checkEq("t6_boot_no_req", 64'(imem_req_valid), 64'd0);
    step();
    imem_resp_valid = 1'b0;
    checkEq("t6_out_idle", 64'(out_valid), 64'd0);
    checkEq("t6_first_req", 64'(imem_req_valid), 64'd1);
    checkEq("t6_first_addr", imem_req_addr, 64'h8000_0000);
    step();
    checkEq("t6_still_idle", 64'(out_valid), 64'd0);

    // PC wraps modulo 2^64 after the top word.
    doReset();
    out_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back(64'h0000_0000_0000_0000);
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    checkEq("t7_wrap_done", 64'(exp_q.size()), 64'd0);

    // Randomized traffic against the model.
    delayLo = 1; delayHi = 3;
    doReset();
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      out_ready      = ($urandom_range(4, 0) < 3);
      redirect_valid = ($urandom_range(15, 0) == 0);
      if ($urandom_range(1, 0) == 0) redirect_pc = {$urandom, $urandom};
      else                           redirect_pc = RESET_PC + 64'($urandom_range(1023, 0));
      step();
      if (idle > 300) break;
    end
    redirect_valid = 1'b0;
    checkEq("rand_progress", 64'(nDeliver >= 100), 64'd1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: the requesting side of the instruction-memory interface. It owns the PC, issues one word-aligned fetch at a time to the instruction memory over a valid/ready request channel, and captures the 32-bit response. It presents the instruction with its PC to decode over a valid/ready output channel. It sits between the instruction ROM/memory and the decode stage, and accepts PC redirects from execute.

## Interface
- `RESET_PC`, default `64'h8000_0000`: first fetch address after reset; equals `PcRst`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `redirect_valid`  in  1  redirect from execute (branch/jump/trap) this cycle.
- `redirect_pc`  in  64  redirect target.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  64  fetch address, equals current PC.
- `imem_resp_valid`  in  1  response valid; never in the same cycle the request is accepted.
- `imem_resp_data`  in  32  fetched instruction.
- `out_valid`  out  1  instruction valid to decode.
- `out_ready`  in  1  decode accepts.
- `out_pc`  out  64  PC of `out_inst`.
- `out_inst`  out  32  instruction.
- `perf_fetch_cnt`  out  64  delivered-instruction count (only with `IFU_PERF_EN`).
- `perf_stall_cnt`  out  64  cycles with `out_valid & ~out_ready` (only with `IFU_PERF_EN`).

## Operation
- States: BOOT, REQ, WAIT, HOLD. Registers: `pc` (64), `drop` (1), `out_pc`, `out_inst`.
- BOOT is entered on reset and goes to REQ unconditionally on the next edge.
- REQ: `imem_req_valid=1`, `imem_req_addr=pc`. If `imem_req_ready`, go to WAIT. Responses arriving in REQ or BOOT are ignored.
- WAIT: on `imem_resp_valid`:
  - If `drop=1`: discard the data, clear `drop`, go to REQ.
  - Otherwise: latch `out_inst=imem_resp_data` and `out_pc=pc`, then go to HOLD.
- HOLD: `out_valid=1`. On `out_ready`, set `pc=pc+4` (mod 2^64) and go to REQ.
- Redirect handling. Redirect has priority over all PC updates, and the last redirect wins.
  - REQ without handshake: `pc=redirect_pc`; stay in REQ.
  - REQ with handshake in the same cycle: `pc=redirect_pc`, `drop=1`, go to WAIT. The old-address response is discarded.
  - WAIT without response: `pc=redirect_pc`, `drop=1`.
  - WAIT with response in the same cycle: discard the response, `pc=redirect_pc`, `drop=0`, go to REQ.
  - HOLD: the buffered instruction is flushed (`out_valid` low next cycle), `pc=redirect_pc`, go to REQ. If `out_ready` is also high that cycle, the handshake still counts as delivered.
- `redirect_pc[1:0]` is used as-is. The alignment fault is raised by execute.
- Exactly one request is outstanding at any time.

## Timing
- Reset values:
  - `imem_req_valid=0`, `imem_req_addr=RESET_PC`
  - `out_valid=0`, `out_pc=0`, `out_inst=0`
  - `pc=RESET_PC`, `drop=0`
  - perf counters 0
- The first request is visible one cycle after `rst` deasserts.
- `imem_req_valid`, `imem_req_addr` and `out_*` are driven from registers/state only, with no combinational path from inputs.
- Latency: response cycle to `out_valid` is 1 cycle. Best case with 1-cycle memory is 3 cycles per instruction (REQ, WAIT, HOLD).
- `imem_req_addr` is held stable while `imem_req_valid & ~imem_req_ready`, except when a redirect changes it.
- An asynchronous reset mid-operation returns to BOOT immediately and abandons the outstanding request.

## Configuration
- `IFU_PERF_EN` defined: `perf_fetch_cnt` increments on each `out_valid & out_ready`, and `perf_stall_cnt` increments on each `out_valid & ~out_ready`. Both are 64-bit and wrap.
- `IFU_PERF_EN` undefined: both ports and counters are absent.

## Test plan
- Reset release, memory always ready, 1-cycle response with data `0x00000413`:
  - First request address is `0x8000_0000`, one cycle after reset release.
  - `out_pc=0x8000_0000`, `out_inst=0x00000413`.
  - Next request address is `0x8000_0004`.
- `imem_req_ready` low for 3 cycles: `imem_req_addr` stays stable at `0x8000_0000`, and exactly one request is accepted.
- Redirect to `0x8000_0100` in WAIT before the response arrives:
  - The old response is not presented (`out_valid` stays 0).
  - The next request address is `0x8000_0100`.
- Redirect in HOLD with `out_ready=0`: `out_valid` drops the next cycle, and the next request address is `redirect_pc`.
- `out_ready` held low for 5 cycles in HOLD:
  - `out_pc` and `out_inst` are stable.
  - With `IFU_PERF_EN`, `perf_stall_cnt=5`, and `perf_fetch_cnt=1` after the accept.
- Assert `rst` while in WAIT, with the response arriving in BOOT: the response is ignored, `out_valid=0`, and the first request goes to `0x8000_0000`.
